// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) reduction constant, xtime helper and
// the sequencer state encoding used by the column engines.
package aes_pkg;

   localparam logic [7:0] GF_POLY = 8'h1b;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } state_e;

   typedef struct packed {
      logic [7:0] m09;
      logic [7:0] m0b;
      logic [7:0] m0d;
      logic [7:0] m0e;
   } inv_mults_t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
   endfunction

   // The four InvMixColumns multiples share one x2/x4/x8 chain per byte.
   function automatic inv_mults_t inv_mults(input logic [7:0] a);
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      inv_mults_t m;
      x2    = xtime(a);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m.m09 = x8 ^ a;
      m.m0b = x8 ^ x2 ^ a;
      m.m0d = x8 ^ x4 ^ a;
      m.m0e = x8 ^ x4 ^ x2;
      return m;
   endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// State-in / state-out valid-ready channel of the InvMixColumns engine.
interface inv_mix_columns_seq_if;

   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;

   modport master (
      output in_valid,
      output in_state,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_state
   );

   modport slave (
      input  in_valid,
      input  in_state,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_state
   );

endinterface

// File: rtl/inv_column_mult.sv
// One 32-bit column through the inverse MixColumns matrix; byte a0 is bits [31:24].
module inv_column_mult
   import aes_pkg::*;
(
   input  logic [31:0] col_i,
   output logic [31:0] col_o
);

   inv_mults_t m [4];

   for (genvar i = 0; i < 4; i++) begin : g_byte
      assign m[i] = inv_mults(col_i[31-8*i -: 8]);
   end

   assign col_o = {
      m[0].m0e ^ m[1].m0b ^ m[2].m0d ^ m[3].m09,
      m[0].m09 ^ m[1].m0e ^ m[2].m0b ^ m[3].m0d,
      m[0].m0d ^ m[1].m09 ^ m[2].m0e ^ m[3].m0b,
      m[0].m0b ^ m[1].m0d ^ m[2].m09 ^ m[3].m0e
   };

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns: captures a state, rewrites COL_PER_CYC columns per
// cycle in place, then holds the result until the consumer takes it.
module inv_mix_columns_seq
   import aes_pkg::*;
#(
   parameter int unsigned COL_PER_CYC = 1
) (
   input logic                  clk,
   input logic                  rst,
   inv_mix_columns_seq_if.slave bus
);

   localparam int unsigned NCYC    = 4 / COL_PER_CYC;
   localparam logic [1:0]  LastCnt = 2'(NCYC - 1);

   state_e            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [3:0][31:0]  work_q, work_d;

   logic [1:0]        col_pos [COL_PER_CYC];
   logic [31:0]       col_out [COL_PER_CYC];

   for (genvar g = 0; g < COL_PER_CYC; g++) begin : g_col
      logic [1:0] col_idx;
      assign col_idx    = 2'(32'(cnt_q) * COL_PER_CYC + 32'(g));
      // Column 0 lives in the most significant word of work_q.
      assign col_pos[g] = ~col_idx;

      inv_column_mult u_col (
         .col_i (work_q[col_pos[g]]),
         .col_o (col_out[g])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               work_d  = bus.in_state;
               cnt_d   = 2'd0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            for (int g = 0; g < COL_PER_CYC; g++) begin
               work_d[col_pos[g]] = col_out[g];
            end
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == LastCnt) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 2'd0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.out_state = work_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: three engines (1, 2 and 4 columns per cycle)
// share stimulus; each keeps its own queue of expected results and accept times.
module tb_inv_mix_columns_seq;

   localparam logic [127:0] FipsIn  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] FipsOut = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] Ones    = 128'h01010101_01010101_01010101_01010101;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [2:0]        vld = 3'b000;
   logic [127:0]      in_state = '0;
   logic              out_ready = 1'b1;
   logic [127:0]      exp_cur = '0;

   logic [2:0]        rdy;
   logic [2:0]        ov;
   logic [2:0][127:0] os;
   int                pend [3];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [127:0] fwd_mix(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         {a0, a1, a2, a3} = s[127-32*c -: 32];
         r[127-32*c -: 32] = {
            gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
            a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
            a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
            gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)
         };
      end
      return r;
   endfunction

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int unsigned Ncyc = 4 >> k;

      inv_mix_columns_seq_if bus ();

      assign bus.in_valid  = vld[k];
      assign bus.in_state  = in_state;
      assign bus.out_ready = out_ready;
      assign rdy[k]        = bus.in_ready;
      assign ov[k]         = bus.out_valid;
      assign os[k]         = bus.out_state;

      inv_mix_columns_seq #(.COL_PER_CYC(1 << k)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );

      logic [127:0] exp_q [$];
      int           acc_q [$];
      logic         ov_prev = 1'b0;
      int           qsize = 0;

      assign pend[k] = qsize;

      // Inputs change just after posedge, so the negedge sees what the next edge will act on.
      always @(negedge clk) begin
         if (rst) begin
            exp_q.delete();
            acc_q.delete();
         end else begin
            if (bus.out_valid && !ov_prev) begin
               if (acc_q.size() > 0)
                  check($sformatf("latency_c%0d", 1 << k), 128'(cyc - acc_q.pop_front()),
                        128'(Ncyc));
               else
                  check($sformatf("spurious_valid_c%0d", 1 << k), 128'(bus.out_valid), 128'd0);
            end
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() > 0)
                  check($sformatf("out_state_c%0d", 1 << k), bus.out_state, exp_q.pop_front());
               else
                  check($sformatf("spurious_out_c%0d", 1 << k), 128'(bus.out_valid), 128'd0);
            end
            if (bus.in_valid && bus.in_ready) begin
               exp_q.push_back(exp_cur);
               acc_q.push_back(cyc + 1);
            end
         end
         ov_prev = bus.out_valid;
         qsize   = exp_q.size();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [127:0] st, input logic [127:0] ex);
      for (int i = 0; i < 100 && rdy != 3'b111; i++) tick();
      check("send_ready", 128'(rdy), 128'd7);
      vld      = 3'b111;
      in_state = st;
      exp_cur  = ex;
      tick();
      vld = 3'b000;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && (rdy != 3'b111 || pend[0] + pend[1] + pend[2] != 0); i++)
         tick();
      check("drain_idle", 128'(rdy), 128'd7);
   endtask

   task automatic check_reset_state(input string tag);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("%s_in_ready%0d", tag, k), 128'(rdy[k]), 128'd1);
         check($sformatf("%s_out_valid%0d", tag, k), 128'(ov[k]), 128'd0);
         check($sformatf("%s_out_state%0d", tag, k), os[k], 128'd0);
      end
   endtask

   initial begin
      logic [127:0] orig;
      logic [127:0] st_b;
      int           t1;
      int           t2;

      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      check_reset_state("reset");

      send(FipsIn, FipsOut);
      drain();
      send('0, '0);
      drain();
      send(Ones, Ones);
      drain();

      // 250 states = 1000 random columns round-tripped through the forward mix.
      for (int n = 0; n < 250; n++) begin
         orig = {$urandom, $urandom, $urandom, $urandom};
         send(fwd_mix(orig), orig);
      end
      drain();

      out_ready = 1'b0;
      send(FipsIn, FipsOut);
      for (int i = 0; i < 20 && ov != 3'b111; i++) tick();
      check("bp_out_valid", 128'(ov), 128'd7);
      for (int i = 0; i < 10; i++) begin
         vld      = 3'b111;
         in_state = {$urandom, $urandom, $urandom, $urandom};
         exp_cur  = '0;
         tick();
         for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_in_ready%0d", k), 128'(rdy[k]), 128'd0);
            check($sformatf("bp_out_state%0d", k), os[k], FipsOut);
         end
      end
      vld       = 3'b000;
      out_ready = 1'b1;
      tick();
      send(Ones, Ones);
      drain();

      orig = {$urandom, $urandom, $urandom, $urandom};
      st_b = fwd_mix(orig);
      vld      = 3'b001;
      in_state = FipsIn;
      exp_cur  = FipsOut;
      for (int i = 0; i < 20 && !rdy[0]; i++) tick();
      tick();
      t1       = cyc;
      in_state = st_b;
      exp_cur  = orig;
      for (int i = 0; i < 20 && !rdy[0]; i++) tick();
      tick();
      t2  = cyc;
      vld = 3'b000;
      check("b2b_interval", 128'(t2 - t1), 128'd6);
      drain();

      out_ready = 1'b0;
      send(FipsIn, FipsOut);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_state("midrst");
      out_ready = 1'b1;
      send(FipsIn, FipsOut);
      drain();

      for (int k = 0; k < 3; k++) check($sformatf("pending%0d", k), 128'(pend[k]), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/inv_mix_columns_seq.md
# inv_mix_columns_seq

Sequential AES InvMixColumns engine for the decryption datapath: it accepts one 128-bit state over a valid/ready handshake and multiplies each of the four 32-bit columns by the inverse MixColumns matrix over GF(2^8). Columns are processed iteratively, COL_PER_CYC columns per clock. The result is held in an output register until the downstream stage accepts it. The block sits between InvShiftRows/InvSubBytes and AddRoundKey in the inverse round, as the counterpart of the existing forward column-mix logic.

## Interface
- COL_PER_CYC, 1, columns transformed per clock; legal values 1, 2, 4; compute phase lasts NCYC = 4/COL_PER_CYC cycles
- clk  in  1  single clock, all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_state is valid
- in_ready  out  1  block can accept a state
- in_state  in  128  state; column c is bits [127-32c -: 32]; byte a0 of a column is its bits [31:24], a3 is bits [7:0]
- out_valid  out  1  out_state is valid
- out_ready  in  1  downstream accepts out_state
- out_state  out  128  InvMixColumns(in_state), same column/byte layout

## Operation
- xtime(a) = (a<<1) ^ (a[7] ? 8'h1b : 8'h00), truncated to 8 bits.
- Build the GF multiples from xtime:
  - 09·a = x8 ^ a
  - 0b·a = x8 ^ x2 ^ a
  - 0d·a = x8 ^ x4 ^ a
  - 0e·a = x8 ^ x4 ^ x2
  - where x2 = xtime(a), x4 = xtime(x2), x8 = xtime(x4).
- Per-column outputs:
  - r0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - r1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - r2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - r3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- FSM states and transitions:
  - IDLE → BUSY on in_valid & in_ready. On that edge, capture in_state into the working register and clear the column counter.
  - BUSY: each cycle, replace columns cnt*COL_PER_CYC … +COL_PER_CYC-1 of the working register with their transformed value, then advance cnt. On the edge where the last group is written, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Counter width is 2 bits. It wraps to 0 only via capture; it never runs free.
- in_ready = (state==IDLE). Inputs are not accepted in BUSY or DONE, even when out_ready is high in DONE.
- out_state is driven from the working register. It must stay stable while out_valid=1 and out_ready=0.
- in_state is sampled only on the accept edge. Later changes to in_state have no effect.
- Reset: state=IDLE, cnt=0, working register=0. Outputs after reset: in_ready=1, out_valid=0, out_state=0.
- Reset mid-operation, in BUSY or DONE: the block aborts and returns to IDLE with the reset values above. No output is produced for the aborted state.

## Timing
- Accept at edge T; compute edges T+1 … T+NCYC; out_valid rises after edge T+NCYC.
- Latency from accept to out_valid: NCYC cycles (4, 2 or 1).
- Minimum initiation interval: NCYC+2 cycles (one IDLE cycle, NCYC BUSY cycles, one DONE cycle), when out_ready is held high.
- out_valid, in_ready and out_state are registered outputs, or decoded from registered state only. There is no combinational in→out path.
- Combinational depth per cycle: COL_PER_CYC parallel column units, each with 3 chained xtime plus XOR trees.

## Structure
- Shared package aes_pkg:
  - constant GF_POLY = 8'h1b
  - function xtime
  - state encoding IDLE/BUSY/DONE
- Sub-module inv_column_mult: purely combinational, 32-bit in → 32-bit out, implements one column with the byte mapping above.
- Top instantiates COL_PER_CYC copies of inv_column_mult via generate. Each copy is indexed by a multiplexer on cnt.

## Test plan
- FIPS-197 vector, COL_PER_CYC=1: in_state=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6 → out_state=128'hdb135345_f20a225c_01010101_c6c6c6c6, with out_valid exactly 4 cycles after accept.
- Round trip: 1000 random columns passed through the forward column-mix logic, then this block, for all three COL_PER_CYC values → result equals the original. Latency must be 4/2/1 cycles respectively.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, with in_valid=1 and in_state toggling → out_state constant, in_ready=0. Release out_ready → returns to IDLE, then accepts the next state.
- Back-to-back: in_valid and out_ready held at 1, two vectors → second accept occurs exactly NCYC+2 cycles after the first, and both results are correct.
- Reset mid-operation: assert rst for 1 cycle on the second BUSY cycle → next cycle out_valid=0, in_ready=1, out_state=0. The following vector 128'h8e4da1bc_… still yields 128'hdb135345_….
- Degenerate inputs: all-zero state → all-zero result; 128'h01010101 repeated four times → same value back.
